scope_trace_reader: RTL
=======================

# scope_trace_reader

Display-side reader of the oscilloscope capture buffer. It sweeps the buffer's 640-entry sample store in step with the VGA raster and converts each 12-bit sample into a screen row. It draws a connected trace by filling the vertical span between adjacent samples, and emits a per-pixel `pixel_on` for the colour mixer. It also tracks whether captures are still arriving and blanks the trace when they go stale.

## Interface
Parameters:
- `SCREEN_W`, 640: visible columns; equal to buffer depth.
- `SCREEN_H`, 480: visible rows.
- `Y_SHIFT`, 3: sample-to-row divisor is 2^Y_SHIFT.
- `TIMEOUT_FRAMES`, 60: frames without a new capture before the trace is declared stale.

Ports:
- `clock`, in, 1: pixel clock; the only clock.
- `reset`, in, 1: synchronous, active-high.
- `h_count`, in, 10: current raster column from the VGA timing generator.
- `v_count`, in, 10: current raster row.
- `video_on`, in, 1: high inside the visible area.
- `fifo_full`, in, 1: capture-complete strobe from the capture buffer, synchronous to `clock`.
- `rd_addr`, out, 10: buffer read index.
- `rd_data`, in, 12: buffer sample, valid 1 cycle after `rd_addr`.
- `pixel_on`, out, 1: trace pixel lit.
- `video_on_d`, out, 1: `video_on` aligned to `pixel_on`.
- `trace_valid`, out, 1: a fresh capture exists.

## Operation
- Reset values: `rd_addr`=0, `pixel_on`=0, `video_on_d`=0, `trace_valid`=0, frame counter=0, `prev_row`=0, state=EMPTY.
- **Capture FSM:**
  - EMPTY to SHOW on a rising edge of `fifo_full`, using a registered previous value. Also clears the frame counter.
  - In SHOW, the frame counter increments on each frame start (`h_count`==0 and `v_count`==0, detected once per frame).
  - Another `fifo_full` rising edge clears the counter.
  - When the counter reaches TIMEOUT_FRAMES, SHOW goes to EMPTY.
  - If a rising edge and a frame start occur in the same cycle, the rising edge wins and the counter clears.
  - `trace_valid` = (state==SHOW).
- **Pipeline:**
  - S0: `rd_addr` <= `h_count` when `h_count` < SCREEN_W, else 0.
  - S1: `rd_data` arrives.
  - S2: `cur_row` = (4095 − `rd_data`) >> Y_SHIFT, saturated to SCREEN_H−1. This is a 12-bit unsigned subtract with no underflow, since `rd_data` ≤ 4095.
  - S3 (registered): `pixel_on` = `video_on` (delayed) & `trace_valid` & (min(`prev_row`,`cur_row`) ≤ `v_count` (delayed) ≤ max(`prev_row`,`cur_row`)).
- **`prev_row` update:**
  - Updates to `cur_row` every cycle the delayed column is < SCREEN_W.
  - At delayed column 0, `prev_row` is forced equal to `cur_row`, so the first column draws a single pixel and there is no wrap from column 639 of the previous line.
- `h_count` and `v_count` are delayed three cycles alongside the data. All comparisons use the delayed copies.
- Reset mid-line: all pipeline stages flush to 0, and `pixel_on` stays 0 until `fifo_full` rises again.

## Timing
- Latency from `h_count` presented to `pixel_on`/`video_on_d`: 3 cycles, fixed. The VGA output stage compensates by delaying sync by 3.
- One column per cycle, no stalls, no back-pressure toward the capture buffer.
- `fifo_full` level is ignored; only its edge matters. A level held high across frames counts as one capture.
- The frame counter saturates at TIMEOUT_FRAMES and does not wrap.

## Structure
- Shared package `scope_pkg`: `SCREEN_W`, `SCREEN_H`, `SAMPLE_W`=12, `ADDR_W`=10, and the FSM enum `trace_state_t` {EMPTY, SHOW}.
- One natural sub-module: `sample_to_row`, the combinational invert/shift/saturate step, reusable by the trigger-level marker.
- Everything else stays in `scope_trace_reader`.

## Test plan
- **Reset, no capture:** ramp `rd_data`, sweep a full frame → `pixel_on` never 1, `trace_valid`=0.
- **Flat trace:** pulse `fifo_full`, buffer all 2048 → row (2047>>3)=255. `pixel_on`=1 only on `v_count`=255, 3 cycles after each column.
- **Steep edge:**
  - Buffer: column 99 = 4095 (row 0), column 100 = 0 (row 511, clamped to 479).
  - Expected: column 100 lit for rows 0..479 inclusive; column 0 lit on a single row.
- **Clamp and extremes:** `rd_data`=0 gives row 479; `rd_data`=4095 gives row 0; `rd_data`=8 gives row 510, clamped to 479.
- **Timeout:**
  - One `fifo_full` pulse, then 60 frame starts with no pulse → `trace_valid` falls on the 60th.
  - A pulse on frame 59 → `trace_valid` stays high.
  - A pulse coincident with a frame start → counter clears to 0.
- **Mid-line reset:** assert `reset` at column 320 for 1 cycle → `pixel_on` 0 next cycle and for the rest of the frame. `rd_addr` restarts tracking `h_count` the cycle after release.

Source files
------------

// File: rtl/scope_pkg.sv
// Shared constants and types for the oscilloscope display path.
package scope_pkg;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int SAMPLE_W = 12;
   localparam int ADDR_W   = 10;

   typedef enum logic {
      EMPTY = 1'b0,
      SHOW  = 1'b1
   } trace_state_t;
endpackage

// File: rtl/sample_to_row.sv
// Maps a 12-bit sample to a screen row: full-scale is the top row, zero the
// bottom, and anything below the visible area clamps to the last row.
module sample_to_row
   import scope_pkg::*;
#(
   parameter int Y_SHIFT = 3,
   parameter int ROW_MAX = SCREEN_H - 1
) (
   input  logic [SAMPLE_W-1:0] sample,
   output logic [ADDR_W-1:0]   row
);
   localparam logic [SAMPLE_W-1:0] ROW_MAX_S = SAMPLE_W'(ROW_MAX);

   logic [SAMPLE_W-1:0] inverted;
   logic [SAMPLE_W-1:0] shifted;

   always_comb begin
      inverted = {SAMPLE_W{1'b1}} - sample;
      shifted  = inverted >> Y_SHIFT;
      row      = (shifted > ROW_MAX_S) ? ADDR_W'(ROW_MAX) : shifted[ADDR_W-1:0];
   end
endmodule

// File: rtl/scope_trace_reader.sv
// Sweeps the capture buffer in step with the raster and lights the pixels that
// join adjacent samples; blanks the trace when captures stop arriving.
module scope_trace_reader
   import scope_pkg::*;
#(
   parameter int SCREEN_W       = scope_pkg::SCREEN_W,
   parameter int SCREEN_H       = scope_pkg::SCREEN_H,
   parameter int Y_SHIFT        = 3,
   parameter int TIMEOUT_FRAMES = 60
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   h_count,
   input  logic [ADDR_W-1:0]   v_count,
   input  logic                video_on,
   input  logic                fifo_full,
   output logic [ADDR_W-1:0]   rd_addr,
   input  logic [SAMPLE_W-1:0] rd_data,
   output logic                pixel_on,
   output logic                video_on_d,
   output logic                trace_valid,
   output trace_state_t        state_dbg
);
   localparam logic [ADDR_W-1:0] COL_LIM = ADDR_W'(SCREEN_W);
   localparam int                CNT_W   = $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_FRAMES);

   trace_state_t     state, state_n;
   logic [CNT_W-1:0] frame_cnt, frame_cnt_n;
   logic             fifo_full_q, at_origin_q;
   logic             ff_rise, at_origin, frame_start;

   assign ff_rise     = fifo_full & ~fifo_full_q;
   assign at_origin   = (h_count == '0) && (v_count == '0);
   assign frame_start = at_origin & ~at_origin_q;
   assign trace_valid = (state == SHOW);
   assign state_dbg   = state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= EMPTY;
         frame_cnt   <= '0;
         fifo_full_q <= 1'b0;
         at_origin_q <= 1'b0;
      end else begin
         state       <= state_n;
         frame_cnt   <= frame_cnt_n;
         fifo_full_q <= fifo_full;
         at_origin_q <= at_origin;
      end
   end

   // A new capture outranks a coincident frame start: the counter clears.
   always_comb begin
      state_n     = state;
      frame_cnt_n = frame_cnt;
      case (state)
         EMPTY: begin
            if (ff_rise) begin
               state_n     = SHOW;
               frame_cnt_n = '0;
            end
         end
         SHOW: begin
            if (ff_rise) begin
               frame_cnt_n = '0;
            end else if (frame_start && (frame_cnt != CNT_MAX)) begin
               frame_cnt_n = frame_cnt + CNT_W'(1);
            end
            if (frame_cnt_n == CNT_MAX) begin
               state_n = EMPTY;
            end
         end
         default: state_n = EMPTY;
      endcase
   end

   // Read port is fixed-latency with no handshake: one registered address per
   // cycle, sample returned on the following cycle, never stalled.
   logic [ADDR_W-1:0] h_d1, h_d2, v_d1, v_d2;
   logic              vo_d1, vo_d2;
   logic [ADDR_W-1:0] cur_row, prev_row, span_start, lo_row, hi_row;
   logic              in_span;

   sample_to_row #(
      .Y_SHIFT (Y_SHIFT),
      .ROW_MAX (SCREEN_H - 1)
   ) u_sample_to_row (
      .sample (rd_data),
      .row    (cur_row)
   );

   // Column 0 starts its own span so a line never joins onto the previous one.
   always_comb begin
      span_start = (h_d2 == '0) ? cur_row : prev_row;
      lo_row     = (span_start < cur_row) ? span_start : cur_row;
      hi_row     = (span_start < cur_row) ? cur_row : span_start;
      in_span    = (v_d2 >= lo_row) && (v_d2 <= hi_row);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_addr    <= '0;
         h_d1       <= '0;
         h_d2       <= '0;
         v_d1       <= '0;
         v_d2       <= '0;
         vo_d1      <= 1'b0;
         vo_d2      <= 1'b0;
         prev_row   <= '0;
         pixel_on   <= 1'b0;
         video_on_d <= 1'b0;
      end else begin
         rd_addr    <= (h_count < COL_LIM) ? h_count : '0;
         h_d1       <= h_count;
         h_d2       <= h_d1;
         v_d1       <= v_count;
         v_d2       <= v_d1;
         vo_d1      <= video_on;
         vo_d2      <= vo_d1;
         video_on_d <= vo_d2;
         pixel_on   <= vo_d2 & trace_valid & in_span;
         if (h_d2 < COL_LIM) begin
            prev_row <= cur_row;
         end
      end
   end
endmodule
